// File: rtl/rv32i_exec_datapath.sv
// RV32I decode/execute/data-memory slice: combinational decode and ALU, async-read byte memory.
// Define DMEM_SUBWORD_EN for byte/halfword accesses; otherwise every access is an aligned word.
`timescale 1ns/1ps
module rv32i_exec_datapath #(
  parameter int DATA_ADDR_SIZE = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        mem_stage,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [31:0] imm,
  output logic        arithmetic,
  output logic        arithmetic_imm,
  output logic        load,
  output logic        store,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic        lui,
  output logic        auipc,
  output logic [31:0] alu_out,
  output logic [31:0] read_data
);
  localparam int MEM_BYTES = 1 << DATA_ADDR_SIZE;

  logic [6:0]  w_opcode;
  logic        w_unknown;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  assign w_opcode       = inst[6:0];
  assign arithmetic     = (w_opcode == 7'b0110011);
  assign arithmetic_imm = (w_opcode == 7'b0010011);
  assign load           = (w_opcode == 7'b0000011);
  assign store          = (w_opcode == 7'b0100011);
  assign branch         = (w_opcode == 7'b1100011);
  assign jal            = (w_opcode == 7'b1101111);
  assign jalr           = (w_opcode == 7'b1100111);
  assign lui            = (w_opcode == 7'b0110111);
  assign auipc          = (w_opcode == 7'b0010111);
  assign w_unknown      = ~(arithmetic | arithmetic_imm | load | store | branch |
                            jal | jalr | lui | auipc);

  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign rd     = (store | branch | w_unknown) ? 5'd0 : inst[11:7];

  assign w_imm_i = {{20{inst[31]}}, inst[31:20]};
  assign w_imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign w_imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign w_imm_u = {inst[31:12], 12'b0};
  assign w_imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    imm = '0;
    if (arithmetic_imm | load | jalr) imm = w_imm_i;
    else if (store)                   imm = w_imm_s;
    else if (branch)                  imm = w_imm_b;
    else if (lui | auipc)             imm = w_imm_u;
    else if (jal)                     imm = w_imm_j;
  end

  logic [31:0] w_op2;
  logic [4:0]  w_shamt;
  logic        w_alt;
  logic [31:0] w_sra;
  logic [31:0] w_alu_res;
  logic        w_taken;

  // Register ops use rs2_data; immediate ops reuse the same ALU with imm, so only R-type can subtract.
  assign w_op2   = arithmetic ? rs2_data : imm;
  assign w_shamt = w_op2[4:0];
  assign w_alt   = funct7[5];
  assign w_sra   = $signed(rs1_data) >>> w_shamt;

  always_comb begin
    w_alu_res = '0;
    case (funct3)
      3'b000:  w_alu_res = (arithmetic && w_alt) ? rs1_data - w_op2 : rs1_data + w_op2;
      3'b001:  w_alu_res = rs1_data << w_shamt;
      3'b010:  w_alu_res = {31'b0, $signed(rs1_data) < $signed(w_op2)};
      3'b011:  w_alu_res = {31'b0, rs1_data < w_op2};
      3'b100:  w_alu_res = rs1_data ^ w_op2;
      3'b101:  w_alu_res = w_alt ? w_sra : (rs1_data >> w_shamt);
      3'b110:  w_alu_res = rs1_data | w_op2;
      default: w_alu_res = rs1_data & w_op2;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      3'b000:  w_taken = (rs1_data == rs2_data);
      3'b001:  w_taken = (rs1_data != rs2_data);
      3'b100:  w_taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  w_taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  w_taken = (rs1_data <  rs2_data);
      3'b111:  w_taken = (rs1_data >= rs2_data);
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    alu_out = '0;
    if (arithmetic | arithmetic_imm) alu_out = w_alu_res;
    else if (load | store)           alu_out = rs1_data + imm;
    else if (branch)                 alu_out = {31'b0, w_taken};
  end

  logic [7:0]                r_mem [MEM_BYTES];
  logic [DATA_ADDR_SIZE-1:0] w_base;
  logic [DATA_ADDR_SIZE-1:0] w_lane_addr [4];
  logic [7:0]                w_rd_byte [4];
  logic [3:0]                w_byte_en;
  logic                      w_we;
  logic [31:0]               w_rd_word;
  logic [31:0]               w_load_val;

`ifdef DMEM_SUBWORD_EN
  assign w_base = alu_out[DATA_ADDR_SIZE-1:0];

  always_comb begin
    case (funct3[1:0])
      2'b00:   w_byte_en = 4'b0001;
      2'b01:   w_byte_en = 4'b0011;
      default: w_byte_en = 4'b1111;
    endcase
  end

  always_comb begin
    case (funct3)
      3'b000:  w_load_val = {{24{w_rd_word[7]}}, w_rd_word[7:0]};
      3'b001:  w_load_val = {{16{w_rd_word[15]}}, w_rd_word[15:0]};
      3'b100:  w_load_val = {24'b0, w_rd_word[7:0]};
      3'b101:  w_load_val = {16'b0, w_rd_word[15:0]};
      default: w_load_val = w_rd_word;
    endcase
  end
`else
  assign w_base     = {alu_out[DATA_ADDR_SIZE-1:2], 2'b00};
  assign w_byte_en  = 4'b1111;
  assign w_load_val = w_rd_word;
`endif

  // Each lane wraps independently, so misaligned accesses roll over the top of memory.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane_addr[gi] = w_base + DATA_ADDR_SIZE'(gi);
      assign w_rd_byte[gi]   = r_mem[w_lane_addr[gi]];
    end
  endgenerate

  assign w_rd_word = {w_rd_byte[3], w_rd_byte[2], w_rd_byte[1], w_rd_byte[0]};
  assign read_data = load ? w_load_val : '0;

  // rst gates the enable combinationally: a low rst blocks the write immediately, contents are kept.
  assign w_we = mem_stage & store & rst;

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_byte_en[i]) r_mem[w_lane_addr[i]] <= rs2_data[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_rv32i_exec_datapath.sv
// Self-checking bench for rv32i_exec_datapath: directed test-plan vectors plus randomized
// decode/ALU and memory traffic against a byte-array reference model.
`timescale 1ns/1ps
module tb_rv32i_exec_datapath;
  localparam int MSZ = 1024;
`ifdef DMEM_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  logic        clk, rst, mem_stage;
  logic [31:0] inst, rs1_data, rs2_data;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm, alu_out, read_data;
  logic        arithmetic, arithmetic_imm, load, store, branch, jal, jalr, lui, auipc;

  int checks = 0;
  int failures = 0;
  logic [7:0] model_mem [MSZ];

  rv32i_exec_datapath #(.DATA_ADDR_SIZE(10)) dut (
    .clk(clk), .rst(rst), .inst(inst), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .mem_stage(mem_stage), .rs1(rs1), .rs2(rs2), .rd(rd), .funct3(funct3), .funct7(funct7),
    .imm(imm), .arithmetic(arithmetic), .arithmetic_imm(arithmetic_imm), .load(load),
    .store(store), .branch(branch), .jal(jal), .jalr(jalr), .lui(lui), .auipc(auipc),
    .alu_out(alu_out), .read_data(read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached before summary");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    logic signed [31:0] s;
    s = signed'(v << (32 - bits));
    return 32'(s >>> (32 - bits));
  endfunction

  function automatic bit slt_s(input logic [31:0] a, input logic [31:0] b);
    return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
  endfunction

  function automatic logic [31:0] model_alu(input bit is_r, input logic [2:0] f3, input bit alt,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (f3)
      3'd0: return (is_r && alt) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return slt_s(a, b) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? ((a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0)) : (a >> sh);
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic bit model_branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return slt_s(a, b);
      3'd5: return !slt_s(a, b);
      3'd6: return a < b;
      3'd7: return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int mem_base(input logic [31:0] ea);
    return SUBWORD ? int'(ea % MSZ) : int'((ea & ~32'd3) % MSZ);
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] f3, input logic [31:0] ea);
    logic [31:0] w;
    int base;
    base = mem_base(ea);
    w = {model_mem[(base + 3) % MSZ], model_mem[(base + 2) % MSZ],
         model_mem[(base + 1) % MSZ], model_mem[base]};
    if (!SUBWORD) return w;
    case (f3)
      3'd0: return sext({24'h0, w[7:0]}, 8);
      3'd1: return sext({16'h0, w[15:0]}, 16);
      3'd4: return {24'h0, w[7:0]};
      3'd5: return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic model_write(input logic [2:0] f3, input logic [31:0] ea, input logic [31:0] d);
    int n;
    int base;
    base = mem_base(ea);
    n = !SUBWORD ? 4 : (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    for (int k = 0; k < n; k++) model_mem[(base + k) % MSZ] = d[8*k +: 8];
  endtask

  function automatic bit is_known(input logic [6:0] op);
    return op == OP_R || op == OP_I || op == OP_LD || op == OP_ST || op == OP_BR ||
           op == OP_JAL || op == OP_JALR || op == OP_LUI || op == OP_AUIPC;
  endfunction

  task automatic apply(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input logic ms);
    @(negedge clk);
    inst = ins; rs1_data = a; rs2_data = b; mem_stage = ms;
    #1;
  endtask

  task automatic commit();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] i_ld(input logic [2:0] f3);
    return {12'h0, 5'd1, f3, 5'd5, OP_LD};
  endfunction

  function automatic logic [31:0] s_st(input logic [2:0] f3);
    return {7'h0, 5'd2, 5'd1, f3, 5'h0, OP_ST};
  endfunction

  task automatic test_reset();
    #1;
    checks++; if ({arithmetic, arithmetic_imm, load, store, branch, jal, jalr, lui, auipc} !== 9'b0) begin
      failures++; $display("FAIL reset_flags got=%09b exp=000000000", {arithmetic, arithmetic_imm, load, store, branch, jal, jalr, lui, auipc}); end
    checks++; if ({imm, alu_out, read_data} !== 96'h0 || rd !== 5'd0) begin
      failures++; $display("FAIL reset_outputs got imm=%08h alu=%08h rd_data=%08h rd=%0d exp all zero", imm, alu_out, read_data, rd); end
    apply(32'h0050_0513, 32'h0, 32'h0, 1'b0);
    $display("txn reset_addi inst=%08h alu_out=%08h rd=%0d", inst, alu_out, rd);
    checks++; if (alu_out !== 32'd5 || rd !== 5'd10) begin
      failures++; $display("FAIL reset_follow got alu=%08h rd=%0d exp alu=00000005 rd=10", alu_out, rd); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_clear_mem();
    for (int i = 0; i < MSZ / 4; i++) begin
      apply(s_st(3'b010), 32'(4 * i), 32'h0, 1'b1);
      commit();
      $display("txn clear addr=%0d", 4 * i);
    end
    mem_stage = 1'b0;
    for (int i = 0; i < MSZ; i++) model_mem[i] = 8'h0;
  endtask

  task automatic test_plan_vectors();
    apply(32'h0050_0513, 32'h0, 32'h0, 1'b0);
    $display("txn addi inst=%08h alu_out=%08h imm=%08h", inst, alu_out, imm);
    checks++; if (arithmetic_imm !== 1'b1 || rd !== 5'd10 || imm !== 32'd5 || alu_out !== 32'd5) begin
      failures++; $display("FAIL addi got ai=%0b rd=%0d imm=%08h alu=%08h exp 1/10/5/5", arithmetic_imm, rd, imm, alu_out); end
    apply({7'h20, 5'd2, 5'd1, 3'b000, 5'd3, OP_R}, 32'd3, 32'd5, 1'b0);
    $display("txn sub alu_out=%08h", alu_out);
    checks++; if (alu_out !== 32'hFFFF_FFFE) begin
      failures++; $display("FAIL sub got=%08h exp=fffffffe", alu_out); end
    apply({7'h20, 5'd2, 5'd1, 3'b101, 5'd3, OP_R}, 32'h8000_0000, 32'd4, 1'b0);
    $display("txn sra alu_out=%08h", alu_out);
    checks++; if (alu_out !== 32'hF800_0000) begin
      failures++; $display("FAIL sra got=%08h exp=f8000000", alu_out); end
    apply({7'h0, 5'd2, 5'd1, 3'b000, 5'd4, OP_BR}, 32'd7, 32'd7, 1'b0);
    $display("txn beq alu_out=%08h", alu_out);
    checks++; if (alu_out !== 32'd1) begin
      failures++; $display("FAIL beq got=%08h exp=00000001", alu_out); end
    apply({7'h0, 5'd2, 5'd1, 3'b001, 5'd4, OP_BR}, 32'd7, 32'd7, 1'b0);
    $display("txn bne alu_out=%08h", alu_out);
    checks++; if (alu_out !== 32'd0) begin
      failures++; $display("FAIL bne got=%08h exp=00000000", alu_out); end
    apply({7'h0, 5'd2, 5'd1, 3'b110, 5'd4, OP_BR}, 32'd1, 32'hFFFF_FFFF, 1'b0);
    $display("txn bltu alu_out=%08h", alu_out);
    checks++; if (alu_out !== 32'd1) begin
      failures++; $display("FAIL bltu got=%08h exp=00000001", alu_out); end
    apply(32'ha4a0_2023, 32'h0, 32'h0, 1'b0);
    $display("txn store_decode store=%0b rd=%0d", store, rd);
    checks++; if (store !== 1'b1 || rd !== 5'd0) begin
      failures++; $display("FAIL store_rd got store=%0b rd=%0d exp store=1 rd=0", store, rd); end
  endtask

  task automatic test_memory_plan();
    apply(s_st(3'b010), 32'd8, 32'h1122_3344, 1'b1);
    commit(); model_write(3'b010, 32'd8, 32'h1122_3344);
    apply(i_ld(3'b000), 32'd11, 32'h0, 1'b0);
    $display("txn lb11 alu_out=%08h read_data=%08h", alu_out, read_data);
    checks++; if (read_data !== (SUBWORD ? 32'h0000_0011 : 32'h1122_3344) || alu_out !== 32'd11) begin
      failures++; $display("FAIL lb_addr11 got=%08h alu=%08h", read_data, alu_out); end
    apply(i_ld(3'b001), 32'd8, 32'h0, 1'b0);
    $display("txn lh8 read_data=%08h", read_data);
    checks++; if (read_data !== (SUBWORD ? 32'h0000_3344 : 32'h1122_3344)) begin
      failures++; $display("FAIL lh_addr8 got=%08h", read_data); end
    apply(s_st(3'b000), 32'd0, 32'h0000_0080, 1'b1);
    commit(); model_write(3'b000, 32'd0, 32'h0000_0080);
    apply(i_ld(3'b000), 32'd0, 32'h0, 1'b0);
    $display("txn lb0 read_data=%08h", read_data);
    checks++; if (read_data !== (SUBWORD ? 32'hFFFF_FF80 : 32'h0000_0080)) begin
      failures++; $display("FAIL lb_addr0 got=%08h", read_data); end
    apply(i_ld(3'b100), 32'd0, 32'h0, 1'b0);
    $display("txn lbu0 read_data=%08h", read_data);
    checks++; if (read_data !== 32'h0000_0080) begin
      failures++; $display("FAIL lbu_addr0 got=%08h exp=00000080", read_data); end
    apply(s_st(3'b010), 32'd1023, 32'hA1B2_C3D4, 1'b1);
    commit(); model_write(3'b010, 32'd1023, 32'hA1B2_C3D4);
    apply(i_ld(3'b010), 32'd1023, 32'h0, 1'b0);
    $display("txn lw1023 read_data=%08h", read_data);
    checks++; if (read_data !== 32'hA1B2_C3D4) begin
      failures++; $display("FAIL lw_wrap got=%08h exp=a1b2c3d4", read_data); end
    apply(i_ld(3'b010), 32'd0, 32'h0, 1'b0);
    $display("txn lw0 read_data=%08h", read_data);
    checks++; if (read_data !== model_read(3'b010, 32'd0)) begin
      failures++; $display("FAIL lw_after_wrap got=%08h exp=%08h", read_data, model_read(3'b010, 32'd0)); end
  endtask

  task automatic test_write_gating();
    apply(s_st(3'b010), 32'd8, 32'hDEAD_BEEF, 1'b0);
    commit();
    apply(i_ld(3'b010), 32'd8, 32'h0, 1'b0);
    $display("txn gate_mem_stage read_data=%08h", read_data);
    checks++; if (read_data !== 32'h1122_3344) begin
      failures++; $display("FAIL gate_mem_stage got=%08h exp=11223344", read_data); end
    @(negedge clk); rst = 1'b0;
    apply(s_st(3'b010), 32'd8, 32'hCAFE_F00D, 1'b1);
    checks++; if (alu_out !== 32'd8) begin
      failures++; $display("FAIL follow_in_reset got=%08h exp=00000008", alu_out); end
    commit(); mem_stage = 1'b0; rst = 1'b1;
    apply(i_ld(3'b010), 32'd8, 32'h0, 1'b0);
    $display("txn gate_reset_held read_data=%08h", read_data);
    checks++; if (read_data !== 32'h1122_3344) begin
      failures++; $display("FAIL gate_reset_held got=%08h exp=11223344", read_data); end
    apply(s_st(3'b010), 32'd8, 32'h0BAD_C0DE, 1'b1);
    #2 rst = 1'b0;
    commit(); mem_stage = 1'b0; rst = 1'b1;
    apply(i_ld(3'b010), 32'd8, 32'h0, 1'b0);
    $display("txn gate_reset_mid read_data=%08h", read_data);
    checks++; if (read_data !== 32'h1122_3344) begin
      failures++; $display("FAIL gate_reset_mid got=%08h exp=11223344", read_data); end
    apply(s_st(3'b010), 32'd8, 32'h5566_7788, 1'b1);
    commit(); model_write(3'b010, 32'd8, 32'h5566_7788);
    apply(i_ld(3'b010), 32'd8, 32'h0, 1'b0);
    $display("txn write_after_reset read_data=%08h", read_data);
    checks++; if (read_data !== 32'h5566_7788) begin
      failures++; $display("FAIL write_after_reset got=%08h exp=55667788", read_data); end
  endtask

  task automatic test_random_decode(input int n);
    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int t = 0; t < n; t++) begin
      int cls;
      logic [4:0] r1, r2, d, e_rd;
      logic [2:0] f3;
      logic [6:0] f7, op;
      logic [11:0] im12;
      logic [12:0] im13;
      logic [19:0] im20;
      logic [20:0] im21;
      logic [31:0] a, b, ins, e_imm, e_alu, e_rdata;
      logic [8:0] e_fl, g_fl;
      cls = $urandom_range(0, 9);
      r1 = 5'($urandom); r2 = 5'($urandom); d = 5'($urandom); f3 = 3'($urandom);
      im12 = 12'($urandom); im13 = {12'($urandom), 1'b0}; im20 = 20'($urandom);
      im21 = {20'($urandom), 1'b0};
      a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      e_imm = 32'h0; e_alu = 32'h0; e_rd = d; e_rdata = 32'h0;
      case (cls)
        0: begin
          f7 = $urandom_range(0, 1) ? 7'h20 : 7'h00;
          ins = {f7, r2, r1, f3, d, OP_R};
          e_alu = model_alu(1'b1, f3, f7[5], a, b);
        end
        1: begin
          if (f3 == 3'd1) im12 = {7'h00, 5'($urandom)};
          if (f3 == 3'd5) im12 = {($urandom_range(0, 1) ? 7'h20 : 7'h00), 5'($urandom)};
          ins = {im12, r1, f3, d, OP_I};
          e_imm = sext({20'h0, im12}, 12);
          e_alu = model_alu(1'b0, f3, im12[10], a, e_imm);
        end
        2: begin
          f3 = ld_f3[$urandom_range(0, 4)];
          ins = {im12, r1, f3, d, OP_LD};
          e_imm = sext({20'h0, im12}, 12); e_alu = a + e_imm;
          e_rdata = model_read(f3, e_alu);
        end
        3: begin
          f3 = 3'($urandom_range(0, 2));
          ins = {im12[11:5], r2, r1, f3, im12[4:0], OP_ST};
          e_imm = sext({20'h0, im12}, 12); e_alu = a + e_imm; e_rd = 5'd0;
        end
        4: begin
          ins = {im13[12], im13[10:5], r2, r1, f3, im13[4:1], im13[11], OP_BR};
          e_imm = sext({19'h0, im13}, 13); e_rd = 5'd0;
          e_alu = model_branch(f3, a, b) ? 32'd1 : 32'd0;
        end
        5: begin
          ins = {im21[20], im21[10:1], im21[11], im21[19:12], d, OP_JAL};
          e_imm = sext({11'h0, im21}, 21);
        end
        6: begin
          ins = {im12, r1, 3'b000, d, OP_JALR};
          e_imm = sext({20'h0, im12}, 12);
        end
        7, 8: begin
          ins = {im20, d, (cls == 7) ? OP_LUI : OP_AUIPC};
          e_imm = {im20, 12'h0};
        end
        default: begin
          do op = 7'($urandom); while (is_known(op));
          ins = {25'($urandom), op};
          e_rd = 5'd0;
        end
      endcase
      e_fl = (cls < 9) ? (9'b1 << (8 - cls)) : 9'b0;
      apply(ins, a, b, 1'b0);
      g_fl = {arithmetic, arithmetic_imm, load, store, branch, jal, jalr, lui, auipc};
      $display("txn rand_dec %0d cls=%0d inst=%08h a=%08h b=%08h alu_out=%08h imm=%08h read_data=%08h",
               t, cls, ins, a, b, alu_out, imm, read_data);
      checks++; if (g_fl !== e_fl) begin failures++; $display("FAIL rand_flags txn=%0d got=%09b exp=%09b", t, g_fl, e_fl); end
      checks++; if (rd !== e_rd) begin failures++; $display("FAIL rand_rd txn=%0d got=%0d exp=%0d", t, rd, e_rd); end
      checks++; if (rs1 !== ins[19:15]) begin failures++; $display("FAIL rand_rs1 txn=%0d got=%0d exp=%0d", t, rs1, ins[19:15]); end
      checks++; if (rs2 !== ins[24:20]) begin failures++; $display("FAIL rand_rs2 txn=%0d got=%0d exp=%0d", t, rs2, ins[24:20]); end
      checks++; if (funct3 !== ins[14:12]) begin failures++; $display("FAIL rand_funct3 txn=%0d got=%0d exp=%0d", t, funct3, ins[14:12]); end
      checks++; if (funct7 !== ins[31:25]) begin failures++; $display("FAIL rand_funct7 txn=%0d got=%02h exp=%02h", t, funct7, ins[31:25]); end
      checks++; if (imm !== e_imm) begin failures++; $display("FAIL rand_imm txn=%0d got=%08h exp=%08h", t, imm, e_imm); end
      checks++; if (alu_out !== e_alu) begin failures++; $display("FAIL rand_alu txn=%0d got=%08h exp=%08h", t, alu_out, e_alu); end
      checks++; if (read_data !== e_rdata) begin failures++; $display("FAIL rand_read txn=%0d got=%08h exp=%08h", t, read_data, e_rdata); end
    end
  endtask

  // Back-to-back stores keep mem_stage high across consecutive edges; loads bias toward the last target.
  task automatic test_back_to_back(input int n);
    logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    int last_tgt;
    int edge_tgt [6] = '{1021, 1022, 1023, 0, 1, 2};
    last_tgt = 0;
    for (int t = 0; t < n; t++) begin
      int tgt;
      bit is_st;
      logic [2:0] f3;
      logic [11:0] im12;
      logic [31:0] e_imm, a, d, ea, ins;
      is_st = ($urandom_range(0, 1) == 1);
      if (!is_st && $urandom_range(0, 1) == 1) tgt = last_tgt;
      else if ($urandom_range(0, 3) == 0) tgt = edge_tgt[$urandom_range(0, 5)];
      else tgt = $urandom_range(0, MSZ - 1);
      im12 = 12'($urandom);
      e_imm = sext({20'h0, im12}, 12);
      a = {22'($urandom), 10'(tgt)} - e_imm;
      ea = a + e_imm;
      d = $urandom;
      if (is_st) begin
        f3 = 3'($urandom_range(0, 2));
        ins = {im12[11:5], 5'd2, 5'd1, f3, im12[4:0], OP_ST};
        apply(ins, a, d, 1'b1);
      end else begin
        f3 = ld_f3[$urandom_range(0, 4)];
        ins = {im12, 5'd1, f3, 5'd6, OP_LD};
        apply(ins, a, d, 1'($urandom_range(0, 1)));
      end
      $display("txn mem %0d %s f3=%0d ea=%08h data=%08h alu_out=%08h read_data=%08h",
               t, is_st ? "st" : "ld", f3, ea, d, alu_out, read_data);
      checks++; if (alu_out !== ea) begin failures++; $display("FAIL mem_addr txn=%0d got=%08h exp=%08h", t, alu_out, ea); end
      checks++; if (read_data !== (is_st ? 32'h0 : model_read(f3, ea))) begin
        failures++; $display("FAIL mem_read txn=%0d got=%08h exp=%08h", t, read_data, is_st ? 32'h0 : model_read(f3, ea)); end
      if (is_st) begin
        commit();
        model_write(f3, ea, d);
        last_tgt = tgt;
      end
    end
    mem_stage = 1'b0;
  endtask

  initial begin
    rst = 1'b0; inst = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0; mem_stage = 1'b0;
    test_reset();
    test_clear_mem();
    test_plan_vectors();
    test_memory_plan();
    test_write_gating();
    test_random_decode(300);
    test_back_to_back(300);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
